// File: rtl/mem_port_arbiter_if.sv
// Shared memory port bundle: fetch/data requester signals plus the memory-side bus.
interface mem_port_arbiter_if;
    // Fetch requester
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic        if_err;
    // Data requester
    logic        dm_req;
    logic [31:0] dm_addr;
    logic        dm_we;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic        dm_done;
    logic        dm_err;
    // Read data returned to whichever requester finished
    logic [31:0] rdata;
    // Memory bus
    logic        mem_req;
    logic        mem_sel;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, dm_req, dm_addr, dm_we, dm_wdata, dm_wstrb,
        input  mem_ready, mem_rdata,
        output if_done, if_err, dm_done, dm_err, rdata,
        output mem_req, mem_sel, mem_addr, mem_we, mem_wdata, mem_wstrb
    );

    // Requesters and memory model side
    modport master (
        output if_req, if_addr, dm_req, dm_addr, dm_we, dm_wdata, dm_wstrb,
        output mem_ready, mem_rdata,
        input  if_done, if_err, dm_done, dm_err, rdata,
        input  mem_req, mem_sel, mem_addr, mem_we, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer for the single shared memory port: fetch vs. data,
// one registered transaction at a time, with optional timeout abort.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mem_port_arbiter_if.slave     bus
);

    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam bit               TO_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              last_gnt_q,  last_gnt_d;   // 1 = data owned the last grant
    logic              mem_req_q,   mem_req_d;
    logic              mem_sel_q,   mem_sel_d;
    logic [31:0]       mem_addr_q,  mem_addr_d;
    logic              mem_we_q,    mem_we_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic [31:0]       rdata_q,     rdata_d;
    logic              if_done_q,   if_done_d;
    logic              if_err_q,    if_err_d;
    logic              dm_done_q,   dm_done_d;
    logic              dm_err_q,    dm_err_d;
    logic              grant_dm;

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_gnt_d  = last_gnt_q;
        mem_req_d   = mem_req_q;
        mem_sel_d   = mem_sel_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        rdata_d     = rdata_q;
        if_done_d   = 1'b0;
        if_err_d    = 1'b0;
        dm_done_d   = 1'b0;
        dm_err_d    = 1'b0;
        // Data wins when alone, or on a tie when fetch had the last grant
        grant_dm    = bus.dm_req & (~bus.if_req | ~last_gnt_q);

        unique case (state_q)
            ST_IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    state_d    = ST_BUSY;
                    cnt_d      = '0;
                    mem_req_d  = 1'b1;
                    mem_sel_d  = grant_dm;
                    last_gnt_d = grant_dm;
                    if (grant_dm) begin
                        mem_addr_d  = bus.dm_addr;
                        mem_we_d    = bus.dm_we;
                        mem_wdata_d = bus.dm_wdata;
                        mem_wstrb_d = bus.dm_wstrb;
                    end else begin
                        mem_addr_d  = bus.if_addr;
                        mem_we_d    = 1'b0;
                        mem_wdata_d = '0;
                        mem_wstrb_d = '0;
                    end
                end
            end
            ST_BUSY: begin
                if (bus.mem_ready) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    rdata_d   = bus.mem_rdata;
                    if_done_d = ~mem_sel_q;
                    dm_done_d = mem_sel_q;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    rdata_d   = '0;
                    if_done_d = ~mem_sel_q;
                    dm_done_d = mem_sel_q;
                    if_err_d  = ~mem_sel_q;
                    dm_err_d  = mem_sel_q;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transaction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            last_gnt_q  <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_sel_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            rdata_q     <= '0;
            if_done_q   <= 1'b0;
            if_err_q    <= 1'b0;
            dm_done_q   <= 1'b0;
            dm_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_gnt_q  <= last_gnt_d;
            mem_req_q   <= mem_req_d;
            mem_sel_q   <= mem_sel_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            rdata_q     <= rdata_d;
            if_done_q   <= if_done_d;
            if_err_q    <= if_err_d;
            dm_done_q   <= dm_done_d;
            dm_err_q    <= dm_err_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_sel   = mem_sel_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.rdata     = rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.if_err    = if_err_q;
    assign bus.dm_done   = dm_done_q;
    assign bus.dm_err    = dm_err_q;

endmodule
